// File: rtl/yutorina_bus_arbiter.sv
// yutorina_bus_arbiter
//   Shares one bus slave port among 4 masters using round-robin arbitration
//   with registered grants. The owner keeps the bus until it releases req_.
//   The owner's address/control/write data is muxed onto the shared bus, and
//   rdy_/r_data are routed back to the owner only.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   m_req_[3:0]           per-master request (active-low)
//   m_grnt_[3:0]          per-master grant (active-low, registered)
//   m_addr/m_as_/m_rw/m_w_data   per-master bus signals, master i at slice i
//   m_r_data/m_rdy_       per-master return path (owner only)
//   s_addr/s_as_/s_rw/s_w_data   shared bus outputs
//   s_r_data/s_rdy_       shared bus return inputs
//
// Optional feature: define YUTORINA_ARB_TIMEOUT_EN to revoke a grant after
//   ARB_TIMEOUT consecutive owned cycles with the owner's as_ high. A revoked
//   master is locked out until it raises req_ for at least one cycle.

module yutorina_bus_arbiter #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int ARB_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          m_req_,
  output logic [3:0]          m_grnt_,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [3:0]          m_as_,
  input  logic [3:0]          m_rw,
  input  logic [4*DATA_W-1:0] m_w_data,
  output logic [4*DATA_W-1:0] m_r_data,
  output logic [3:0]          m_rdy_,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_as_,
  output logic                s_rw,
  output logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic                s_rdy_
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] rr_ptr, rr_ptr_nxt;
  logic [3:0] grnt_nxt;
  logic       owner_vld;
  logic       expire;
  logic       release_now;
  logic [3:0] lockout;
  logic [3:0] eligible;
  logic [2:0] pick_idle, pick_hand;

  assign owner_vld = (state == OWNED);

  // Returns {hit, index} of the first set bit of cand at or after start, wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!r[2] && cand[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign eligible    = ~m_req_ & ~lockout;
  assign release_now = m_req_[owner] | expire;
  assign pick_idle   = rr_pick(eligible, rr_ptr);
  // Handover search excludes the releasing master so a same-cycle re-request
  // is served after every other pending master.
  assign pick_hand   = rr_pick(eligible & ~(4'b0001 << owner), owner + 2'd1);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_nxt = OWNED;
          owner_nxt = pick_idle[1:0];
        end
      end
      OWNED: begin
        if (release_now) begin
          rr_ptr_nxt = owner + 2'd1;
          if (pick_hand[2]) owner_nxt = pick_hand[1:0];
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    grnt_nxt = (state_nxt == OWNED) ? ~(4'b0001 << owner_nxt) : '1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      m_grnt_ <= '1;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
      m_grnt_ <= grnt_nxt;
    end
  end

`ifdef YUTORINA_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(ARB_TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  // Revoke on the cycle whose increment would bring the count to ARB_TIMEOUT.
  assign expire = owner_vld && m_as_[owner] && (idle_cnt == CW'(ARB_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
      lockout  <= '0;
    end else begin
      if (!owner_vld || !m_as_[owner] || release_now) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;
      lockout <= lockout & ~m_req_;
      if (expire) lockout[owner] <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^ARB_TIMEOUT;
  assign expire  = 1'b0;
  assign lockout = '0;
`endif

  always_comb begin
    s_addr   = '0;
    s_as_    = 1'b1;
    s_rw     = 1'b1;
    s_w_data = '0;
    m_rdy_   = '1;
    m_r_data = '0;
    if (owner_vld) begin
      s_addr   = m_addr[owner*ADDR_W +: ADDR_W];
      s_as_    = m_as_[owner];
      s_rw     = m_rw[owner];
      s_w_data = m_w_data[owner*DATA_W +: DATA_W];
      m_rdy_[owner] = s_rdy_;
      m_r_data[owner*DATA_W +: DATA_W] = s_r_data;
    end
  end

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
module tb_yutorina_bus_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    m_req_;
  logic [3:0]    m_grnt_;
  logic [4*AW-1:0] m_addr;
  logic [3:0]    m_as_;
  logic [3:0]    m_rw;
  logic [4*DW-1:0] m_w_data;
  logic [4*DW-1:0] m_r_data;
  logic [3:0]    m_rdy_;
  logic [AW-1:0] s_addr;
  logic          s_as_;
  logic          s_rw;
  logic [DW-1:0] s_w_data;
  logic [DW-1:0] s_r_data;
  logic          s_rdy_;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] grnt;
  } exp_t;
  exp_t sb[$];

  yutorina_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_w_data(m_w_data),
    .m_r_data(m_r_data), .m_rdy_(m_rdy_), .s_addr(s_addr), .s_as_(s_as_),
    .s_rw(s_rw), .s_w_data(s_w_data), .s_r_data(s_r_data), .s_rdy_(s_rdy_)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive requests, queue the grant expected after the next edge, then
  // compare it against the DUT once the edge has passed.
  task automatic step(input logic [3:0] req, input logic [3:0] eg, input string tag);
    exp_t e;
    m_req_ = req;
    sb.push_back('{tag, eg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, {60'd0, m_grnt_}, {60'd0, e.grnt});
    check({e.tag, "_onehot"}, {63'd0, ($countones(~m_grnt_) <= 1)}, 64'd1);
  endtask

  function automatic logic [3:0] g(input int k);
    logic [3:0] v;
    v = 4'b1111;
    v[k % 4] = 1'b0;
    return v;
  endfunction

  task automatic check_idle_bus(input string tag);
    check({tag, "_as"},   {63'd0, s_as_}, 64'd1);
    check({tag, "_rw"},   {63'd0, s_rw}, 64'd1);
    check({tag, "_addr"}, {34'd0, s_addr}, 64'd0);
    check({tag, "_wd"},   {32'd0, s_w_data}, 64'd0);
    check({tag, "_rdy"},  {60'd0, m_rdy_}, 64'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    m_req_   = 4'b0000;
    m_as_    = 4'b1111;
    m_rw     = 4'b1111;
    s_rdy_   = 1'b1;
    s_r_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*AW +: AW]   = (i == 2) ? AW'('h100) : AW'('h1000 + i);
      m_w_data[i*DW +: DW] = 32'hA5A50000 + i;
    end

    // Reset with all requests low
    step(4'b0000, 4'b1111, "rst0");
    check("rst0_as", {63'd0, s_as_}, 64'd1);
    step(4'b0000, 4'b1111, "rst1");
    check("rst1_as", {63'd0, s_as_}, 64'd1);
    rst = 1'b1;
    step(4'b0000, 4'b1110, "first_grant");
    step(4'b1111, 4'b1111, "rel0");       // rr_ptr -> 1
    check_idle_bus("idle0");

    // Single master read
    step(4'b1011, 4'b1011, "single_grant");
    m_as_[2] = 1'b0;
    s_rdy_   = 1'b0;
    s_r_data = 32'hDEADBEEF;
    #1;
    check("single_addr", {34'd0, s_addr}, 64'h100);
    check("single_as", {63'd0, s_as_}, 64'd0);
    check("single_rw", {63'd0, s_rw}, 64'd1);
    check("single_wd", {32'd0, s_w_data}, 64'hA5A50002);
    check("single_rdy", {60'd0, m_rdy_}, 64'b1011);
    for (int i = 0; i < 4; i++)
      check($sformatf("single_rdata%0d", i), {32'd0, m_r_data[i*DW +: DW]},
            (i == 2) ? 64'hDEADBEEF : 64'd0);
    m_as_  = 4'b1111;
    s_rdy_ = 1'b1;
    step(4'b1111, 4'b1111, "single_rel");

    // Round-robin with every master requesting: 0,1,2,3,0 with no gaps
    rst = 1'b0;
    step(4'b1111, 4'b1111, "rst_rr");
    rst = 1'b1;
    step(4'b0000, g(0), "rr_grant0");
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, g(k), $sformatf("rr_hold%0d_a", k));
      step(4'b0000, g(k), $sformatf("rr_hold%0d_b", k));
      step(4'b0000 | (4'b0001 << k), g(k + 1), $sformatf("rr_handover%0d", k));
    end
    step(4'b1111, 4'b1111, "rr_idle");    // owner 0 releases, rr_ptr -> 1
    check_idle_bus("idle1");

    // Hold: master 1 owns while master 0 keeps requesting
    step(4'b1101, 4'b1101, "hold_grant1");
    for (int i = 0; i < 4; i++)
      step(4'b1100, 4'b1101, $sformatf("hold%0d", i));
    step(4'b1110, 4'b1110, "hold_handover");
    m_as_ = 4'b0000;
    m_rw  = 4'b0000;
    step(4'b1111, 4'b1111, "hold_idle");  // rr_ptr -> 1
    check_idle_bus("idle2");
    m_as_ = 4'b1111;
    m_rw  = 4'b1111;

    // Simultaneous requests with rr_ptr=2: {0,3} -> 3 wins
    step(4'b1101, 4'b1101, "sim_pre_grant");
    step(4'b1111, 4'b1111, "sim_pre_rel"); // rr_ptr -> 2
    step(4'b0110, 4'b0111, "sim_3wins");
    step(4'b1110, 4'b1110, "sim_then0");
    step(4'b1111, 4'b1111, "sim_idle");

    // Reset mid-transfer
    step(4'b1011, 4'b1011, "mid_grant");
    m_as_[2] = 1'b0;
    #1;
    check("mid_as_low", {63'd0, s_as_}, 64'd0);
    rst = 1'b0;
    step(4'b1011, 4'b1111, "mid_rst");
    check("mid_rst_as", {63'd0, s_as_}, 64'd1);
    m_as_ = 4'b1111;
    rst   = 1'b1;
    step(4'b1111, 4'b1111, "post_rst_idle");

`ifdef YUTORINA_ARB_TIMEOUT_EN
    // Timeout: master 3 owns with as_ high while master 1 requests
    step(4'b0111, 4'b0111, "to_grant3");
    for (int i = 0; i < 7; i++)
      step(4'b0101, 4'b0111, $sformatf("to_hold%0d", i));
    step(4'b0101, 4'b1101, "to_revoke");
    step(4'b0101, 4'b1101, "to_m1_own");
    step(4'b0111, 4'b1111, "to_locked_a");
    step(4'b0111, 4'b1111, "to_locked_b");
    step(4'b1111, 4'b1111, "to_unlock");
    step(4'b0111, 4'b0111, "to_regrant3");
    step(4'b1111, 4'b1111, "to_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
